// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order word-aligned requests to instruction
// memory, DEPTH-entry prefetch queue toward decode, and redirect handling
// that flushes the queue and discards stale in-flight responses.
// Optional feature macro: FETCH_PERF_EN (adds stall / flushed-response counters).
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [XLEN-1:0]          imem_rsp_data,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [XLEN-1:0]          inst_pc,
  output logic [XLEN-1:0]          inst_data,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_flushed_rsp
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;     // pc belonging to the next response to capture
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  logic [XLEN-1:0] redir_pc;
  logic [CW:0]     in_use;
  logic            credit_ok, req_fire, rsp_fire, push, pop;
  logic            unused_redir_lsbs;

  assign unused_redir_lsbs = ^redirect_pc[1:0];
  assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};

  // Credits count both queued entries and responses still in flight, so a
  // returning response always has a slot waiting for it.
  assign in_use    = {1'b0, outst_q} + {1'b0, count_q};
  assign credit_ok = in_use < DEPTH_W;

  assign imem_req_valid = (state_q == RUN) && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding (e.g. one crossing a reset) is ignored.
  assign rsp_fire       = imem_rsp_valid && (outst_q != '0);
  assign push           = rsp_fire && (state_q == RUN) && !redirect_valid;
  assign inst_valid     = (count_q != '0);
  assign pop            = inst_valid && inst_ready && !redirect_valid;
  assign inst_pc        = inst_valid ? pc_mem[rd_ptr_q]   : '0;
  assign inst_data      = inst_valid ? data_mem[rd_ptr_q] : '0;
  assign fifo_level     = count_q;

  // Next-state: FSM, fetch pointer, credit/discard counters and queue pointers.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(rsp_fire);
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (push)     rsp_pc_d   = rsp_pc_q + XLEN'(4);
    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      discard_d  = outst_d;
      state_d    = (outst_d != '0) ? FLUSH : RUN;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      case (state_q)
        BOOT:  state_d = RUN;
        FLUSH: begin
          discard_d = discard_q - CW'(rsp_fire);
          if (discard_d == '0) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage; contents are only visible through the valid-gated head.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
      data_mem[wr_ptr_q] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters: RUN cycles without an accepted request, dropped responses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
      perf_flushed_rsp  <= '0;
    end else begin
      if ((state_q == RUN) && !req_fire && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (rsp_fire && !push && (perf_flushed_rsp != '1))
        perf_flushed_rsp <= perf_flushed_rsp + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural in-order memory with
// randomised latency/readiness, and a program-order scoreboard of the pcs
// decode should see (sequential from the last reset or redirect target).
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid, inst_valid, inst_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, inst_pc, inst_data;
  logic [2:0]  fifo_level;
  logic        req2_valid, inst2_valid;
  logic [31:0] req2_addr, inst2_pc, inst2_data;
  logic [2:0]  lvl2;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushed_rsp, perf2_stall, perf2_flushed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_data(inst_data),
    .fifo_level(fifo_level)
`ifdef FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flushed_rsp(perf_flushed_rsp)
`endif
  );

  // Second instance only checks fetch address wrap from the top of memory.
  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(req2_valid), .imem_req_ready(1'b1), .imem_req_addr(req2_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .inst_valid(inst2_valid), .inst_ready(1'b0), .inst_pc(inst2_pc), .inst_data(inst2_data),
    .fifo_level(lvl2)
`ifdef FETCH_PERF_EN
    , .perf_stall_cycles(perf2_stall), .perf_flushed_rsp(perf2_flushed)
`endif
  );

  int          errors = 0, checks = 0, cyc = 0, last_due = 0, consumed = 0;
  int          lat_min = 1, lat_max = 1, n_out, c0;
  bit          mem_ready = 1'b1, inject = 1'b0;
  logic [31:0] exp_pc = 32'h0, a;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_log[$];

  function automatic logic [31:0] f(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, score consumption, record accepts,
  // then check hold/credit properties after the edge.
  task automatic step();
    bit          stall;
    logic [31:0] saddr;
    int          d;
    imem_req_ready = mem_ready;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = f(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else if (inject) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_BAD0;
    end
    if (reset && !redirect_valid && inst_valid && inst_ready) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_data", inst_data, f(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (reset && imem_req_valid && imem_req_ready) begin
      d = cyc + $urandom_range(lat_min, lat_max);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(d);
      acc_log.push_back(imem_req_addr);
    end
    if (reset && redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    stall = reset && !redirect_valid && imem_req_valid && !imem_req_ready;
    saddr = imem_req_addr;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!reset) begin
      pend_addr.delete();
      pend_due.delete();
      last_due = 0;
      exp_pc   = 32'h0;
    end
    if (stall) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, saddr);
    end
    chk("credit", 32'((32'(fifo_level) + pend_addr.size()) <= DEPTH), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_inst_data"}, inst_data, 32'h0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    step(); step();
    chk_reset_outputs("rst");
    chk("rst_addr2", req2_addr, 32'hFFFF_FFFC);

    // 1: streaming, first request one cycle after release, address wrap on dut2
    reset = 1'b1;
    step();
    chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_first_addr", imem_req_addr, 32'h0);
    chk("t5_wrap_first", req2_addr, 32'hFFFF_FFFC);
    step();
    chk("t1_second_addr", imem_req_addr, 32'h4);
    chk("t5_wrap_second", req2_addr, 32'h0);
    for (int i = 0; i < 10 && !inst_valid; i++) step();
    chk("t1_inst_valid", 32'(inst_valid), 32'd1);
    chk("t1_first_pc", inst_pc, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_sustain", 32'(inst_valid), 32'd1);
    end
    chk("t1_consumed", 32'(consumed), 32'd8);

    // 2: decode stalled, queue fills to DEPTH then requests stop
    reset = 1'b0; step();
    acc_log.delete();
    reset = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t2_accepts", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) chk("t2_addr", acc_log[i], 32'(i * 4));
    chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t2_level", 32'(fifo_level), 32'd4);
    inst_ready = 1'b1;
    for (int i = 0; i < 5 && !imem_req_valid; i++) step();
    chk("t2_resume_addr", imem_req_addr, 32'h10);

    // 3: redirect with two responses still in flight
    lat_min = 6; lat_max = 6;
    for (int i = 0; i < 20 && pend_addr.size() < 2; i++) step();
    n_out = pend_addr.size();
    chk("t3_setup", 32'(n_out >= 2), 32'd1);
    mem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0; mem_ready = 1'b1; lat_min = 1; lat_max = 1;
    chk("t3_inst_valid", 32'(inst_valid), 32'd0);
    chk("t3_flush_no_req", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 20 && !imem_req_valid; i++) step();
    chk("t3_drained", 32'(pend_addr.size()), 32'd0);
    chk("t3_addr", imem_req_addr, 32'h100);
    for (int i = 0; i < 10 && !inst_valid; i++) step();
    chk("t3_first_pc", inst_pc, 32'h100);
`ifdef FETCH_PERF_EN
    chk("t3_perf_flushed", perf_flushed_rsp, 32'(n_out));
`endif

    // 4: redirect coincides with a response and a request accept
    for (int i = 0; i < 5; i++) step();
    chk("t4_setup", 32'(imem_req_valid && pend_addr.size() == 1 && pend_due[0] <= cyc), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("t4_inst_valid", 32'(inst_valid), 32'd0);
    chk("t4_level", 32'(fifo_level), 32'd0);
    chk("t4_flush_no_req", 32'(imem_req_valid), 32'd0);
    step();
    chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_addr", imem_req_addr, 32'h200);

    // 5: memory not ready for 3 cycles holds address
    a = imem_req_addr;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_addr_hold", imem_req_addr, a);
    end
    mem_ready = 1'b1;
    step();
    chk("t5_next_addr", imem_req_addr, a + 32'd4);

    // 6: reset mid-transaction, late response ignored
    inst_ready = 1'b0;
    for (int i = 0; i < 20 && !(fifo_level == 3'd3 && pend_addr.size() == 1); i++) step();
    chk("t6_setup", 32'(fifo_level == 3'd3 && pend_addr.size() == 1), 32'd1);
    reset = 1'b0;
    step();
    chk_reset_outputs("t6");
    reset = 1'b1; inject = 1'b1;
    step(); step();
    inject = 1'b0;
    chk("t6_late_level", 32'(fifo_level), 32'd0);
    chk("t6_late_valid", 32'(inst_valid), 32'd0);
    step();
    chk("t6_restart_valid", 32'(inst_valid), 32'd1);
    chk("t6_restart_pc", inst_pc, 32'h0);

    // Random traffic with occasional redirects
    c0 = consumed;
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      mem_ready  = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end
      step();
      redirect_valid = 1'b0;
    end
    chk("rand_progress", 32'((consumed - c0) > 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
